sine_phase_sequencer: RTL

Upstream driver for the iterative CORDIC sine stage. A phase accumulator advances by a frequency tuning word on every accepted sample strobe and wraps modulo 2π in the shared fixed-point format. The block issues a one-cycle update to the CORDIC stage and holds the angle stable for the whole computation. It then captures the sine result and presents it as a one-cycle-valid sample to the downstream DAC/stream logic.

---
 rtl/sine_phase_sequencer_pkg.sv | 19 +
 rtl/sine_phase_sequencer_if.sv | 12 +
 rtl/sine_phase_sequencer_phase_accum.sv | 42 ++++
 rtl/sine_phase_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sine_phase_sequencer_pkg.sv
// Shared fixed-point constants and state encoding for the sine phase sequencer.
// Angles are radians scaled by 2^FIX_SHIFT; one full turn is TWO_PI.
package sine_phase_sequencer_pkg;

    localparam int FIX_SHIFT         = 13;
    localparam int PI2               = 12868;      // round(pi/2 * 2^13)
    localparam int TWO_PI            = 4 * PI2;    // 51472 = 0xC910
    localparam int AG_CONST          = 4975;       // CORDIC gain 0.60725 * 2^13
    localparam int WAIT_BUSY_TIMEOUT = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CAPTURE   = 3'd4
    } state_t;

endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Start/ready handshake between the sequencer (master) and the CORDIC sine stage (slave).
interface sine_phase_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             update;
    logic [WIDTH-1:0] angle;
    logic             ready;
    logic [WIDTH-1:0] sine;

    modport master (output update, output angle, input ready, input sine);
    modport slave  (input update, input angle, output ready, output sine);
endinterface

// File: rtl/sine_phase_sequencer_phase_accum.sv
// Phase accumulator: saturated tuning word, wrap modulo TWO_PI, load beats advance.
module sine_phase_sequencer_phase_accum
    import sine_phase_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] phase_init,
    input  logic [WIDTH-1:0] ftw,
    output logic [WIDTH-1:0] phase
);

    localparam logic [WIDTH:0]   TWO_PI_W  = (WIDTH+1)'(TWO_PI);
    localparam logic [WIDTH-1:0] TWO_PI_M1 = WIDTH'(TWO_PI - 1);

    logic [WIDTH-1:0] ftw_sat;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] wrapped;

    // On a combined load+advance the freshly loaded value is the base of the add.
    always_comb begin
        ftw_sat = ({1'b0, ftw} >= TWO_PI_W) ? TWO_PI_M1 : ftw;
        base    = load ? phase_init : phase;
        sum     = {1'b0, base} + {1'b0, ftw_sat};
        wrapped = (sum >= TWO_PI_W) ? WIDTH'(sum - TWO_PI_W) : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
        end else if (advance) begin
            phase <= wrapped;
        end else if (load) begin
            phase <= phase_init;
        end
    end

endmodule

// File: rtl/sine_phase_sequencer.sv
// Sequencer that issues phase angles to the CORDIC sine stage and captures its result.
//   state     | meaning
//   IDLE      | waiting for an enabled strobe
//   ISSUE     | update pulse, angle held
//   WAIT_BUSY | waiting for the stage to drop ready
//   WAIT_DONE | waiting for ready to return
//   CAPTURE   | sample_valid pulse
module sine_phase_sequencer
    import sine_phase_sequencer_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              ftw,
    input  logic [WIDTH-1:0]              phase_init,
    input  logic                          load,
    input  logic                          strobe,
    input  logic                          clear_flags,
    sine_phase_sequencer_if.master        cordic,
    output logic [WIDTH-1:0]              sample,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          overrun,
    output logic                          error
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_t           state, state_next;
    logic [TW-1:0]    timer, timer_next;
    logic             accept;
    logic             timeout;
    logic             capture_en;
    logic             overrun_set;
    logic [WIDTH-1:0] phase;

    sine_phase_sequencer_phase_accum #(
        .WIDTH (WIDTH)
    ) u_phase_accum (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .advance    (accept),
        .phase_init (phase_init),
        .ftw        (ftw),
        .phase      (phase)
    );

    // Timer is a down-counter loaded on entry to each wait state; expiry at zero.
    always_comb begin
        state_next    = state;
        timer_next    = timer;
        accept        = 1'b0;
        timeout       = 1'b0;
        capture_en    = 1'b0;
        cordic.update = 1'b0;
        case (state)
            S_IDLE: begin
                if (strobe && enable) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cordic.update = 1'b1;
                timer_next    = TW'(WAIT_BUSY_TIMEOUT);
                state_next    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!cordic.ready) begin
                    timer_next = TW'(BUSY_TIMEOUT);
                    state_next = S_WAIT_DONE;
                end else if (timer == '0) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (cordic.ready) begin
                    capture_en = 1'b1;
                    state_next = S_CAPTURE;
                end else if (timer == '0) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            S_CAPTURE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy         = (state != S_IDLE);
    assign sample_valid = (state == S_CAPTURE);
    assign overrun_set  = strobe && busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            cordic.angle <= '0;
            sample       <= '0;
            overrun      <= 1'b0;
            error        <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (accept) begin
                cordic.angle <= load ? phase_init : phase;
            end
            if (capture_en) begin
                sample <= cordic.sine;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
            if (timeout) begin
                error <= 1'b1;
            end else if (clear_flags) begin
                error <= 1'b0;
            end
        end
    end

endmodule
